// File: rtl/dip_pkg.sv
// Shared types and default sizes for the DiP tile address generator.
package dip_pkg;

    localparam int DEF_ARR    = 4;
    localparam int DEF_ADDR_W = 24;
    localparam int DEF_DIM_W  = 10;

    typedef enum logic [1:0] {
        KIND_W   = 2'b00,
        KIND_IN  = 2'b01,
        KIND_OUT = 2'b10
    } req_kind_e;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CHECK     = 3'd1,
        S_LOAD_W    = 3'd2,
        S_STREAM_IN = 3'd3,
        S_DRAIN_OUT = 3'd4,
        S_NEXT_TILE = 3'd5,
        S_FIN       = 3'd6
    } state_e;

endpackage

// File: rtl/dip_tile_addr_gen_if.sv
// Memory request port of the DiP tile address generator (valid/ready, one address per beat).
interface dip_tile_addr_gen_if
    import dip_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LANE_W = 2
);

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    req_kind_e         req_kind;
    logic [LANE_W-1:0] req_lane;
    logic              req_first;

    modport master (
        output req_valid, req_addr, req_kind, req_lane, req_first,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_addr, req_kind, req_lane, req_first,
        output req_ready
    );

endinterface

// File: rtl/dip_stride_ctr.sv
// Two-level loop counter: lane runs 0..2^LANE_W-1 inside rows 0..outer_max, with
// the address kept as base + row*stride + lane by incremental adds only.
module dip_stride_ctr #(
    parameter int ADDR_W = 24,
    parameter int DIM_W  = 10,
    parameter int LANE_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] base,
    input  logic [DIM_W-1:0]  stride,
    input  logic [DIM_W-1:0]  outer_max,
    output logic [ADDR_W-1:0] addr,
    output logic [LANE_W-1:0] lane,
    output logic              last
);

    logic [ADDR_W-1:0] row_addr;
    logic [ADDR_W-1:0] row_next;
    logic [DIM_W-1:0]  outer;

    assign row_next = row_addr + ADDR_W'(stride);
    assign last     = (&lane) && (outer == outer_max);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_addr <= '0;
            addr     <= '0;
            lane     <= '0;
            outer    <= '0;
        end else if (load) begin
            row_addr <= base;
            addr     <= base;
            lane     <= '0;
            outer    <= '0;
        end else if (step) begin
            if (&lane) begin
                lane     <= '0;
                outer    <= outer + DIM_W'(1);
                row_addr <= row_next;
                addr     <= row_next;
            end else begin
                lane <= lane + LANE_W'(1);
                addr <= addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/dip_tile_addr_gen.sv
// DiP tile sequencer: walks ARR x ARR weight tiles, issuing weight/input/output requests.
// Optional perf_stall/perf_req counters are built when DIP_PERF_CNT_EN is defined.
module dip_tile_addr_gen
    import dip_pkg::*;
#(
    parameter int ARR    = DEF_ARR,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DIM_W  = DEF_DIM_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [DIM_W-1:0]   dim_m,
    input  logic [DIM_W-1:0]   dim_n,
    input  logic [DIM_W-1:0]   dim_k,
    input  logic [ADDR_W-1:0]  base_w,
    input  logic [ADDR_W-1:0]  base_in,
    input  logic [ADDR_W-1:0]  base_out,
    dip_tile_addr_gen_if.master req,
    output logic               busy,
    output logic               done,
    output logic               err
`ifdef DIP_PERF_CNT_EN
    ,
    output logic [31:0]        perf_stall,
    output logic [31:0]        perf_req
`endif
);

    localparam int LANE_W = $clog2(ARR);
    localparam logic [ADDR_W-1:0] ARR_A = ADDR_W'(ARR);

    state_e            state;
    logic [DIM_W-1:0]  m_r, n_r, k_r, i_r, j_r;
    logic [ADDR_W-1:0] base_in_r, w_jb, w_b, in_b, out_b, w_b_nxt, w_load_base;
    logic [ADDR_W-1:0] w_addr, in_addr, out_addr;
    logic [LANE_W-1:0] w_lane, in_lane, out_lane;
    logic              w_last, in_last, out_last, i_last, j_last, cfg_bad, accept;
    logic              w_load, w_step, in_load, in_step, out_load, out_step;

    assign accept  = req.req_valid && req.req_ready;
    assign cfg_bad = (m_r == '0) || (n_r == '0) || (k_r == '0) ||
                     (n_r[LANE_W-1:0] != '0) || (k_r[LANE_W-1:0] != '0);
    assign i_last  = (i_r == (n_r >> LANE_W) - DIM_W'(1));
    assign j_last  = (j_r == (k_r >> LANE_W) - DIM_W'(1));

    // Weight tile origin: next i moves down ARR rows, an i wrap moves right ARR columns.
    assign w_b_nxt     = i_last ? (w_jb + ARR_A) : (w_b + (ADDR_W'(k_r) << LANE_W));
    assign w_load_base = (state == S_NEXT_TILE) ? w_b_nxt : w_b;

    assign w_load   = (state == S_CHECK) || (state == S_NEXT_TILE);
    assign w_step   = accept && (state == S_LOAD_W);
    assign in_step  = accept && (state == S_STREAM_IN);
    assign out_step = accept && (state == S_DRAIN_OUT);
    assign in_load  = w_step && w_last;
    assign out_load = in_step && in_last;

    dip_stride_ctr #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .LANE_W(LANE_W)) u_w_ctr (
        .clk(clk), .rst_n(rst_n), .load(w_load), .step(w_step), .base(w_load_base),
        .stride(k_r), .outer_max(DIM_W'(ARR - 1)), .addr(w_addr), .lane(w_lane), .last(w_last)
    );

    dip_stride_ctr #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .LANE_W(LANE_W)) u_in_ctr (
        .clk(clk), .rst_n(rst_n), .load(in_load), .step(in_step), .base(in_b),
        .stride(n_r), .outer_max(m_r - DIM_W'(1)), .addr(in_addr), .lane(in_lane), .last(in_last)
    );

    dip_stride_ctr #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .LANE_W(LANE_W)) u_out_ctr (
        .clk(clk), .rst_n(rst_n), .load(out_load), .step(out_step), .base(out_b),
        .stride(k_r), .outer_max(m_r - DIM_W'(1)), .addr(out_addr), .lane(out_lane), .last(out_last)
    );

    // NOTE: combinational outputs get a default before the case so no latch is inferred.
    always_comb begin
        req.req_addr = w_addr;
        req.req_lane = w_lane;
        case (req.req_kind)
            KIND_IN: begin
                req.req_addr = in_addr;
                req.req_lane = in_lane;
            end
            KIND_OUT: begin
                req.req_addr = out_addr;
                req.req_lane = out_lane;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            req.req_valid <= 1'b0;
            req.req_kind  <= KIND_W;
            req.req_first <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            m_r           <= '0;
            n_r           <= '0;
            k_r           <= '0;
            i_r           <= '0;
            j_r           <= '0;
            base_in_r     <= '0;
            w_jb          <= '0;
            w_b           <= '0;
            in_b          <= '0;
            out_b         <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    m_r       <= dim_m;
                    n_r       <= dim_n;
                    k_r       <= dim_k;
                    base_in_r <= base_in;
                    w_jb      <= base_w;
                    w_b       <= base_w;
                    in_b      <= base_in;
                    out_b     <= base_out;
                    err       <= 1'b0;
                    busy      <= 1'b1;
                    state     <= S_CHECK;
                end
                S_CHECK: if (cfg_bad) begin
                    err   <= 1'b1;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_FIN;
                end else begin
                    i_r           <= '0;
                    j_r           <= '0;
                    req.req_valid <= 1'b1;
                    req.req_kind  <= KIND_W;
                    state         <= S_LOAD_W;
                end
                // Phase changes happen on the last accept so the stream has no bubble.
                S_LOAD_W: if (w_step && w_last) begin
                    req.req_kind <= KIND_IN;
                    state        <= S_STREAM_IN;
                end
                S_STREAM_IN: if (in_step && in_last) begin
                    req.req_kind  <= KIND_OUT;
                    req.req_first <= (i_r == '0);
                    state         <= S_DRAIN_OUT;
                end
                S_DRAIN_OUT: if (out_step && out_last) begin
                    req.req_valid <= 1'b0;
                    req.req_first <= 1'b0;
                    state         <= S_NEXT_TILE;
                end
                S_NEXT_TILE: begin
                    w_b <= w_b_nxt;
                    if (i_last) begin
                        i_r   <= '0;
                        j_r   <= j_r + DIM_W'(1);
                        w_jb  <= w_jb + ARR_A;
                        in_b  <= base_in_r;
                        out_b <= out_b + ARR_A;
                    end else begin
                        i_r  <= i_r + DIM_W'(1);
                        in_b <= in_b + ARR_A;
                    end
                    if (i_last && j_last) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_FIN;
                    end else begin
                        req.req_valid <= 1'b1;
                        req.req_kind  <= KIND_W;
                        state         <= S_LOAD_W;
                    end
                end
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef DIP_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall <= '0;
            perf_req   <= '0;
        end else if (state == S_IDLE && start) begin
            perf_stall <= '0;
            perf_req   <= '0;
        end else begin
            if (req.req_valid && !req.req_ready && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
            if (accept && perf_req != '1) perf_req <= perf_req + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dip_tile_addr_gen.sv
// Self-checking bench for dip_tile_addr_gen: table-driven jobs, random jobs against
// a loop-nest reference model, plus reset-abort and backpressure sequences.
module tb_dip_tile_addr_gen;
    import dip_pkg::*;

    localparam int ARR    = 4;
    localparam int ADDR_W = 24;
    localparam int DIM_W  = 10;
    localparam int LANE_W = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [DIM_W-1:0]  dim_m = '0, dim_n = '0, dim_k = '0;
    logic [ADDR_W-1:0] base_w = '0, base_in = '0, base_out = '0;
    logic              busy, done, err;
`ifdef DIP_PERF_CNT_EN
    logic [31:0]       perf_stall, perf_req;
`endif

    dip_tile_addr_gen_if #(.ADDR_W(ADDR_W), .LANE_W(LANE_W)) bus ();

    dip_tile_addr_gen #(.ARR(ARR), .ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dim_m(dim_m), .dim_n(dim_n), .dim_k(dim_k),
        .base_w(base_w), .base_in(base_in), .base_out(base_out),
        .req(bus), .busy(busy), .done(done), .err(err)
`ifdef DIP_PERF_CNT_EN
        , .perf_stall(perf_stall), .perf_req(perf_req)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [1:0]        kind;
        logic [LANE_W-1:0] lane;
        logic              first;
    } req_t;

    typedef struct {
        int                m, n, k;
        logic [ADDR_W-1:0] bw, bin, bout;
        int                mode;      // 0 ready=1, 1 random ready, 2 five-cycle stall in STREAM_IN
        int                poke;      // pulse start mid-job
        int                exp_err;
        int                exp_cnt;
        logic [ADDR_W-1:0] exp_w_last, exp_o_first, exp_o_last;
    } job_t;

    req_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: the plain tile/row/lane loop nest with each address taken from its formula.
    task automatic build_model(input int m, input int n, input int k,
                               input logic [ADDR_W-1:0] bw, input logic [ADDR_W-1:0] bin,
                               input logic [ADDR_W-1:0] bout);
        req_t e;
        exp_q.delete();
        if (m == 0 || n == 0 || k == 0 || n % ARR != 0 || k % ARR != 0) return;
        for (int j = 0; j < k / ARR; j++) begin
            for (int i = 0; i < n / ARR; i++) begin
                for (int r = 0; r < ARR; r++)
                    for (int c = 0; c < ARR; c++) begin
                        e.addr = ADDR_W'(int'(bw) + k * (ARR * i + r) + ARR * j + c);
                        e.kind = 2'b00; e.lane = LANE_W'(c); e.first = 1'b0;
                        exp_q.push_back(e);
                    end
                for (int h = 0; h < m; h++)
                    for (int c = 0; c < ARR; c++) begin
                        e.addr = ADDR_W'(int'(bin) + n * h + ARR * i + c);
                        e.kind = 2'b01; e.lane = LANE_W'(c); e.first = 1'b0;
                        exp_q.push_back(e);
                    end
                for (int h = 0; h < m; h++)
                    for (int c = 0; c < ARR; c++) begin
                        e.addr = ADDR_W'(int'(bout) + k * h + ARR * j + c);
                        e.kind = 2'b10; e.lane = LANE_W'(c); e.first = (i == 0);
                        exp_q.push_back(e);
                    end
            end
        end
    endtask

    task automatic run_job(input job_t jb, input string tag);
        int n_acc = 0, done_cyc = -1, stall_left = 0, in_acc = 0;
        bit stall_done = 0, prev_stall = 0, o_seen = 0;
        req_t prev, e;
        logic [ADDR_W-1:0] w_last_a = '0, o_first_a = '0, o_last_a = '0;

        build_model(jb.m, jb.n, jb.k, jb.bw, jb.bin, jb.bout);
        @(negedge clk);
        dim_m = DIM_W'(jb.m); dim_n = DIM_W'(jb.n); dim_k = DIM_W'(jb.k);
        base_w = jb.bw; base_in = jb.bin; base_out = jb.bout;
        start = 1'b1;
        bus.req_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 4000 && done_cyc < 0; cyc++) begin
            if (cyc == 0) begin
                check({tag, " busy_after_start"}, 32'(busy), 32'd1);
                check({tag, " err_cleared_on_start"}, 32'(err), 32'd0);
            end
            if (jb.poke != 0 && cyc == 10) begin start = 1'b1; dim_m = DIM_W'(jb.m + 1); end
            if (jb.poke != 0 && cyc == 11) begin start = 1'b0; dim_m = DIM_W'(jb.m); end
            case (jb.mode)
                0: bus.req_ready = 1'b1;
                1: bus.req_ready = ($urandom_range(0, 2) != 0);
                default: begin
                    if (!stall_done && bus.req_valid && bus.req_kind == KIND_IN && in_acc == 2) begin
                        stall_left = 5;
                        stall_done = 1;
                    end
                    bus.req_ready = (stall_left == 0);
                    if (stall_left > 0) stall_left--;
                end
            endcase
            if (prev_stall) begin
                check({tag, " hold_valid"}, 32'(bus.req_valid), 32'd1);
                check({tag, " hold_addr"}, 32'(bus.req_addr), 32'(prev.addr));
                check({tag, " hold_lane"}, 32'(bus.req_lane), 32'(prev.lane));
                check({tag, " hold_kind"}, 32'(bus.req_kind), 32'(prev.kind));
                check({tag, " hold_first"}, 32'(bus.req_first), 32'(prev.first));
            end
            prev_stall = bus.req_valid && !bus.req_ready;
            prev.addr = bus.req_addr; prev.lane = bus.req_lane;
            prev.kind = bus.req_kind; prev.first = bus.req_first;
            if (bus.req_valid && bus.req_ready) begin
                if (n_acc < exp_q.size()) begin
                    e = exp_q[n_acc];
                    check({tag, " addr"}, 32'(bus.req_addr), 32'(e.addr));
                    check({tag, " kind"}, 32'(bus.req_kind), 32'(e.kind));
                    check({tag, " lane"}, 32'(bus.req_lane), 32'(e.lane));
                    check({tag, " first"}, 32'(bus.req_first), 32'(e.first));
                end
                if (bus.req_kind == KIND_W) w_last_a = bus.req_addr;
                if (bus.req_kind == KIND_IN) in_acc++;
                if (bus.req_kind == KIND_OUT) begin
                    if (!o_seen) o_first_a = bus.req_addr;
                    o_seen = 1;
                    o_last_a = bus.req_addr;
                end
                n_acc++;
            end
            if (done) begin
                done_cyc = cyc;
                check({tag, " busy_low_at_done"}, 32'(busy), 32'd0);
            end
            @(negedge clk);
        end
        check({tag, " done_seen"}, 32'(done_cyc >= 0), 32'd1);
        check({tag, " done_one_cycle"}, 32'(done), 32'd0);
        check({tag, " idle_busy"}, 32'(busy), 32'd0);
        check({tag, " idle_valid"}, 32'(bus.req_valid), 32'd0);
        check({tag, " err"}, 32'(err), 32'(jb.exp_err));
        check({tag, " req_count"}, 32'(n_acc), 32'(jb.exp_cnt));
        check({tag, " model_count"}, 32'(n_acc), 32'(exp_q.size()));
        if (jb.exp_err != 0) check({tag, " err_done_latency"}, 32'(done_cyc), 32'd1);
        if (jb.exp_cnt > 0) begin
            check({tag, " last_w_addr"}, 32'(w_last_a), 32'(jb.exp_w_last));
            check({tag, " first_out_addr"}, 32'(o_first_a), 32'(jb.exp_o_first));
            check({tag, " last_out_addr"}, 32'(o_last_a), 32'(jb.exp_o_last));
        end
`ifdef DIP_PERF_CNT_EN
        check({tag, " perf_req"}, perf_req, 32'(n_acc));
`endif
    endtask

    job_t tbl[8];
    job_t rj;
    bit   done_any;

    initial begin
        //          m  n  k  bw       bin      bout        mode poke err cnt w_last     o_first     o_last
        tbl[0] = '{2, 4, 4, 24'h100, 24'h200, 24'h300,    0,   0,   0,  32, 24'h10F, 24'h300,    24'h307};
        tbl[1] = '{1, 8, 4, 24'h100, 24'h200, 24'h300,    0,   0,   0,  48, 24'h11F, 24'h300,    24'h303};
        tbl[2] = '{2, 6, 4, 24'h100, 24'h200, 24'h300,    0,   0,   1,   0, 24'h0,   24'h0,      24'h0};
        tbl[3] = '{2, 4, 4, 24'h100, 24'h200, 24'h300,    2,   0,   0,  32, 24'h10F, 24'h300,    24'h307};
        tbl[4] = '{1, 4, 4, 24'h100, 24'h200, 24'hFFFFFE, 0,   0,   0,  24, 24'h10F, 24'hFFFFFE, 24'h000001};
        tbl[5] = '{2, 4, 8, 24'h100, 24'h200, 24'h300,    1,   1,   0,  64, 24'h11F, 24'h300,    24'h30F};
        tbl[6] = '{0, 4, 4, 24'h100, 24'h200, 24'h300,    0,   0,   1,   0, 24'h0,   24'h0,      24'h0};
        tbl[7] = '{2, 4, 6, 24'h100, 24'h200, 24'h300,    1,   0,   1,   0, 24'h0,   24'h0,      24'h0};

        bus.req_ready = 1'b1;
        #12;
        check("reset valid", 32'(bus.req_valid), 32'd0);
        check("reset addr", 32'(bus.req_addr), 32'd0);
        check("reset kind", 32'(bus.req_kind), 32'd0);
        check("reset lane", 32'(bus.req_lane), 32'd0);
        check("reset first", 32'(bus.req_first), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int t = 0; t < 8; t++) run_job(tbl[t], $sformatf("tbl%0d", t));

        // Reset in the middle of weight preload: everything drops at once, no done pulse.
        @(negedge clk);
        dim_m = 10'd2; dim_n = 10'd4; dim_k = 10'd4;
        base_w = 24'h100; base_in = 24'h200; base_out = 24'h300;
        bus.req_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("abort pre valid", 32'(bus.req_valid), 32'd1);
        check("abort pre addr", 32'(bus.req_addr), 32'h103);
        rst_n = 1'b0;
        #1;
        check("abort valid", 32'(bus.req_valid), 32'd0);
        check("abort addr", 32'(bus.req_addr), 32'd0);
        check("abort kind", 32'(bus.req_kind), 32'd0);
        check("abort lane", 32'(bus.req_lane), 32'd0);
        check("abort first", 32'(bus.req_first), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort err", 32'(err), 32'd0);
        done_any = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (done) done_any = 1;
        end
        check("abort no_done", 32'(done_any), 32'd0);
        check("abort idle_busy", 32'(busy), 32'd0);

        for (int t = 0; t < 24; t++) begin
            rj.m = $urandom_range(1, 3);
            rj.n = ARR * $urandom_range(1, 2);
            rj.k = ARR * $urandom_range(1, 2);
            if ($urandom_range(0, 5) == 0) rj.n = rj.n + 2;
            rj.bw = ADDR_W'($urandom); rj.bin = ADDR_W'($urandom); rj.bout = ADDR_W'($urandom);
            rj.mode = 1;
            rj.poke = 0;
            rj.exp_err = (rj.n % ARR != 0) ? 1 : 0;
            rj.exp_cnt = rj.exp_err ? 0 : (rj.k / ARR) * (rj.n / ARR) * (ARR * ARR + 2 * rj.m * ARR);
            rj.exp_w_last  = ADDR_W'(int'(rj.bw) + rj.k * (rj.n - 1) + rj.k - 1);
            rj.exp_o_first = rj.bout;
            rj.exp_o_last  = ADDR_W'(int'(rj.bout) + rj.k * (rj.m - 1) + rj.k - 1);
            run_job(rj, $sformatf("rnd%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
